// File: rtl/trivium_out_fifo_if.sv
// Handshake bundle between the Trivium XOR stage, the output FIFO and the byte consumer.
interface trivium_out_fifo_if #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 256
);
    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] wr_data;
    logic              wr_en;
    logic              flush;
    logic              rd_ready;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic [1:0]        fifo_cnd;
    logic [AW:0]       level;
    logic [7:0]        ovf_cnt;

    modport master (
        output wr_data, wr_en, flush, rd_ready,
        input  rd_data, rd_valid, fifo_cnd, level, ovf_cnt
    );

    modport slave (
        input  wr_data, wr_en, flush, rd_ready,
        output rd_data, rd_valid, fifo_cnd, level, ovf_cnt
    );
endinterface

// File: rtl/trivium_out_fifo.sv
// Show-ahead ciphertext FIFO holding one cipher block; reports empty/partial/full/overflow
// back to the cipher through fifo_cnd.
module trivium_out_fifo #(
    parameter int  DATA_W = 8,
    parameter int  DEPTH  = 256,
    localparam int AW     = $clog2(DEPTH)
) (
    input logic               clk,
    input logic               rst,
    trivium_out_fifo_if.slave bus
);
    localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [AW:0]       level;
    logic [7:0]        ovf_cnt;
    logic              ovf_err;
    logic              full, rd_valid, pop, push, drop;

    assign full     = (level == FULL_LVL);
    assign rd_valid = (level != '0);
    assign pop      = rd_valid & bus.rd_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts the write.
    assign push     = bus.wr_en & (~full | pop);
    assign drop     = bus.wr_en & full & ~pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
            ovf_err <= 1'b0;
        end else if (bus.flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level   <= '0;
            ovf_cnt <= '0;
            ovf_err <= 1'b0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                level <= level + 1'b1;
            else if (pop && !push)
                level <= level - 1'b1;
            if (drop) begin
                ovf_err <= 1'b1;
                if (ovf_cnt != 8'hFF) ovf_cnt <= ovf_cnt + 1'b1;
            end
        end
    end

    // Storage is deliberately not reset; it is only read while level is non-zero.
    always_ff @(posedge clk) begin
        if (push && !bus.flush) mem[wr_ptr] <= bus.wr_data;
    end

    always_comb begin
        bus.fifo_cnd = 2'b00;
        if (ovf_err)       bus.fifo_cnd = 2'b11;
        else if (full)     bus.fifo_cnd = 2'b10;
        else if (rd_valid) bus.fifo_cnd = 2'b01;
    end

    assign bus.rd_valid = rd_valid;
    assign bus.rd_data  = rd_valid ? mem[rd_ptr] : '0;
    assign bus.level    = level;
    assign bus.ovf_cnt  = ovf_cnt;
endmodule
